// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: sequential instruction fetch with a DEPTH-entry prefetch FIFO and redirect flush
module if_prefetch_queue #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  output logic                         o_i_valid_addr,
  output logic [ADDR_W-1:0]            o_i_addr,
  input  logic                         i_i_valid_inst,
  input  logic [INST_W-1:0]            i_i_inst,
  output logic                         o_inst_valid,
  output logic [INST_W-1:0]            o_inst,
  output logic [ADDR_W-1:0]            o_inst_addr,
  input  logic                         i_inst_ready,
  input  logic                         i_redirect_valid,
  input  logic [ADDR_W-1:0]            i_redirect_addr,
  output logic [$clog2(DEPTH+1)-1:0]   o_q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] fetch_pc, req_addr;
  logic              outstanding, discard;
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              issue, resp, push, pop;
  assign issue = !i_redirect_valid && !outstanding && (o_q_count != CW'(DEPTH));
  assign resp = outstanding & i_i_valid_inst;
  assign push = resp & !discard & !i_redirect_valid;
  assign pop = o_inst_valid & i_inst_ready & !i_redirect_valid;
  assign o_inst_valid = o_q_count != '0;
  assign o_inst = inst_q[rd_ptr];
  assign o_inst_addr = addr_q[rd_ptr];
  // Fetch side: one request in flight at a time; a redirect retargets the PC and marks any in-flight reply stale
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_i_valid_addr <= 1'b0;
      o_i_addr       <= '0;
      fetch_pc       <= RESET_PC;
      req_addr       <= '0;
      outstanding    <= 1'b0;
      discard        <= 1'b0;
    end else begin
      o_i_valid_addr <= issue;
      if (issue) begin
        o_i_addr <= fetch_pc;
        req_addr <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
      if (i_redirect_valid) fetch_pc <= i_redirect_addr;
      outstanding <= issue | (outstanding & !resp);
      discard     <= outstanding & !resp & (discard | i_redirect_valid);
    end
  end
  // Queue side: redirect flush wins over push and pop in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_q_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (i_redirect_valid) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_q_count <= '0;
    end else begin
      if (push) begin
        inst_q[wr_ptr] <= i_i_inst;
        addr_q[wr_ptr] <= req_addr;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_q_count <= o_q_count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed checks of fetch, backpressure, redirect, wrap and reset
module tb_if_prefetch_queue;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        o_i_valid_addr;
  logic [63:0] o_i_addr;
  logic        i_i_valid_inst;
  logic [31:0] i_i_inst;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [63:0] o_inst_addr;
  logic        i_inst_ready = 1'b0;
  logic        i_redirect_valid = 1'b0;
  logic [63:0] i_redirect_addr = '0;
  logic [2:0]  o_q_count;

  logic        w_rst_n = 1'b0;
  logic        w_oval;
  logic [63:0] w_oaddr;
  logic        w_iv = 1'b0;
  logic        w_pend = 1'b0;
  logic        w_ivalid;
  logic [31:0] w_inst;
  logic [63:0] w_iaddr;
  logic [2:0]  w_cnt;

  logic        mem_en = 1'b1;
  int          lat = 1;
  logic        mdl_v = 1'b0;
  logic [31:0] mdl_d = '0;
  logic        man_v = 1'b0;
  logic [31:0] man_d = '0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [63:0] maddr = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  assign i_i_valid_inst = mem_en ? mdl_v : man_v;
  assign i_i_inst = mem_en ? mdl_d : man_d;

  if_prefetch_queue dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_i_valid_addr(o_i_valid_addr), .o_i_addr(o_i_addr),
    .i_i_valid_inst(i_i_valid_inst), .i_i_inst(i_i_inst),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_addr(o_inst_addr),
    .i_inst_ready(i_inst_ready),
    .i_redirect_valid(i_redirect_valid), .i_redirect_addr(i_redirect_addr),
    .o_q_count(o_q_count)
  );

  if_prefetch_queue #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .i_clk(i_clk), .i_rst_n(w_rst_n),
    .o_i_valid_addr(w_oval), .o_i_addr(w_oaddr),
    .i_i_valid_inst(w_iv), .i_i_inst(32'h1234_5678),
    .o_inst_valid(w_ivalid), .o_inst(w_inst), .o_inst_addr(w_iaddr),
    .i_inst_ready(1'b1),
    .i_redirect_valid(1'b0), .i_redirect_addr(64'd0),
    .o_q_count(w_cnt)
  );

  // memory model: reply with addr^A5A5A5A5 lat cycles after the request cycle
  always @(posedge i_clk) begin
    #1;
    mdl_v = 1'b0;
    if (!i_rst_n) pend = 1'b0;
    else begin
      if (pend) begin
        if (cnt == 0) begin
          mdl_v = 1'b1;
          mdl_d = maddr[31:0] ^ 32'hA5A5_A5A5;
          pend = 1'b0;
        end else cnt--;
      end
      if (o_i_valid_addr) begin
        pend = 1'b1;
        cnt = lat - 1;
        maddr = o_i_addr;
      end
    end
  end

  // latency-1 responder for the wrap instance
  always @(posedge i_clk) begin
    #1;
    w_iv = w_pend;
    w_pend = w_oval;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset;
    i_rst_n = 1'b0;
    tick;
    i_rst_n = 1'b1;
  endtask

  initial begin
    int nreq, npop, last;
    logic [63:0] eaddr, paddr;
    logic [63:0] wexp [3];
    wexp[0] = 64'hFFFF_FFFF_FFFF_FFFC;
    wexp[1] = 64'h0;
    wexp[2] = 64'h4;

    tick;
    chk("rst_vaddr", 64'(o_i_valid_addr), 64'd0);
    chk("rst_addr", o_i_addr, 64'd0);
    chk("rst_ivalid", 64'(o_inst_valid), 64'd0);
    chk("rst_inst", 64'(o_inst), 64'd0);
    chk("rst_iaddr", o_inst_addr, 64'd0);
    chk("rst_cnt", 64'(o_q_count), 64'd0);

    lat = 1;
    i_inst_ready = 1'b1;
    do_reset;
    nreq = 0; npop = 0; last = 0; eaddr = '0; paddr = '0;
    for (int t = 1; t <= 20; t++) begin
      tick;
      if (o_i_valid_addr) begin
        chk("seq_addr", o_i_addr, eaddr);
        if (nreq > 0) chk("seq_gap", 64'(t - last), 64'd3);
        last = t;
        eaddr += 64'd4;
        nreq++;
      end
      if (o_inst_valid) begin
        chk("seq_iaddr", o_inst_addr, paddr);
        chk("seq_inst", 64'(o_inst), 64'(paddr[31:0] ^ 32'hA5A5_A5A5));
        paddr += 64'd4;
        npop++;
      end
    end
    chk("seq_nreq", 64'(nreq), 64'd7);
    chk("seq_npop", 64'(npop), 64'd6);

    i_inst_ready = 1'b0;
    do_reset;
    repeat (12) tick;
    chk("bp_full", 64'(o_q_count), 64'd4);
    chk("bp_head", o_inst_addr, 64'd0);
    chk("bp_hinst", 64'(o_inst), 64'hA5A5_A5A5);
    repeat (4) begin
      tick;
      chk("bp_noreq", 64'(o_i_valid_addr), 64'd0);
    end
    i_inst_ready = 1'b1;
    tick;
    i_inst_ready = 1'b0;
    chk("bp_pop_cnt", 64'(o_q_count), 64'd3);
    chk("bp_pop_noreq", 64'(o_i_valid_addr), 64'd0);
    chk("bp_pop_head", o_inst_addr, 64'd4);
    tick;
    chk("bp_req", 64'(o_i_valid_addr), 64'd1);
    chk("bp_req_addr", o_i_addr, 64'h10);

    lat = 3;
    do_reset;
    repeat (12) tick;
    chk("rd_pre_cnt", 64'(o_q_count), 64'd2);
    i_redirect_valid = 1'b1;
    i_redirect_addr = 64'h1000;
    tick;
    i_redirect_valid = 1'b0;
    chk("rd_cnt", 64'(o_q_count), 64'd0);
    chk("rd_ivalid", 64'(o_inst_valid), 64'd0);
    chk("rd_noreq", 64'(o_i_valid_addr), 64'd0);
    i_inst_ready = 1'b1;
    repeat (2) begin
      tick;
      chk("rd_drop", {61'd0, o_i_valid_addr, o_q_count[1:0]} | 64'(o_q_count[2]), 64'd0);
    end
    tick;
    chk("rd_req", 64'(o_i_valid_addr), 64'd1);
    chk("rd_req_addr", o_i_addr, 64'h1000);
    repeat (4) tick;
    chk("rd_ivalid2", 64'(o_inst_valid), 64'd1);
    chk("rd_iaddr", o_inst_addr, 64'h1000);
    chk("rd_inst", 64'(o_inst), 64'hA5A5_B5A5);

    lat = 1;
    i_inst_ready = 1'b0;
    do_reset;
    repeat (8) tick;
    chk("rp_pre_cnt", 64'(o_q_count), 64'd2);
    i_redirect_valid = 1'b1;
    i_redirect_addr = 64'h2000;
    i_inst_ready = 1'b1;
    tick;
    i_redirect_valid = 1'b0;
    chk("rp_cnt", 64'(o_q_count), 64'd0);
    chk("rp_ivalid", 64'(o_inst_valid), 64'd0);
    tick;
    chk("rp_req", 64'(o_i_valid_addr), 64'd1);
    chk("rp_req_addr", o_i_addr, 64'h2000);
    chk("rp_cnt2", 64'(o_q_count), 64'd0);
    repeat (2) tick;
    chk("rp_ivalid2", 64'(o_inst_valid), 64'd1);
    chk("rp_iaddr", o_inst_addr, 64'h2000);
    chk("rp_inst", 64'(o_inst), 64'hA5A5_85A5);

    lat = 3;
    i_inst_ready = 1'b0;
    do_reset;
    repeat (16) tick;
    chk("mr_pre_cnt", 64'(o_q_count), 64'd3);
    chk("mr_pre_req", 64'(o_i_valid_addr), 64'd1);
    chk("mr_pre_addr", o_i_addr, 64'hC);
    i_rst_n = 1'b0;
    mem_en = 1'b0;
    #1;
    chk("mr_vaddr", 64'(o_i_valid_addr), 64'd0);
    chk("mr_addr", o_i_addr, 64'd0);
    chk("mr_ivalid", 64'(o_inst_valid), 64'd0);
    chk("mr_inst", 64'(o_inst), 64'd0);
    chk("mr_iaddr", o_inst_addr, 64'd0);
    chk("mr_cnt", 64'(o_q_count), 64'd0);
    tick;
    i_rst_n = 1'b1;
    man_v = 1'b1;
    man_d = 32'hDEAD_BEEF;
    tick;
    man_v = 1'b0;
    chk("mr_req", 64'(o_i_valid_addr), 64'd1);
    chk("mr_req_addr", o_i_addr, 64'd0);
    chk("mr_spur_cnt", 64'(o_q_count), 64'd0);
    tick;
    chk("mr_spur_cnt2", 64'(o_q_count), 64'd0);
    chk("mr_spur_valid", 64'(o_inst_valid), 64'd0);

    tick;
    w_rst_n = 1'b1;
    nreq = 0; npop = 0;
    for (int t = 1; t <= 7; t++) begin
      tick;
      if (w_oval) begin
        if (nreq < 3) chk("wr_addr", w_oaddr, wexp[nreq]);
        nreq++;
      end
      if (w_ivalid) begin
        if (npop < 3) chk("wr_iaddr", w_iaddr, wexp[npop]);
        npop++;
      end
    end
    chk("wr_nreq", 64'(nreq), 64'd3);
    chk("wr_npop", 64'(npop), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Parametrised instruction-fetch stage and successor to the single-entry fetch unit. It generates sequential fetch addresses to instruction memory and buffers returned instructions with their addresses in a DEPTH-entry FIFO.
- Decode consumes the FIFO through a valid/ready handshake.
- Execute redirects the stream on taken jumps; the redirect flushes the FIFO and discards the stale in-flight response.

Parameters:
- ADDR_W, 64, fetch address width.
- INST_W, 32, instruction width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, sequential address increment.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- o_i_valid_addr  out  1  fetch request pulse to instruction memory.
- o_i_addr  out  ADDR_W  fetch address; holds its last value when o_i_valid_addr=0.
- i_i_valid_inst  in  1  instruction memory response valid.
- i_i_inst  in  INST_W  instruction memory response data.
- o_inst_valid  out  1  FIFO head valid to decode.
- o_inst  out  INST_W  FIFO head instruction.
- o_inst_addr  out  ADDR_W  address of the FIFO head instruction.
- i_inst_ready  in  1  decode accepts the head this cycle.
- i_redirect_valid  in  1  jump/redirect from execute.
- i_redirect_addr  in  ADDR_W  redirect target.
- o_q_count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (i_clk, i_rst_n asynchronous active-low):
  - Outputs: o_i_valid_addr=0, o_i_addr=0, o_inst_valid=0, o_inst=0, o_inst_addr=0, o_q_count=0.
  - Internal: fetch_pc=RESET_PC, outstanding=0, discard=0.
  - Assertion mid-operation clears everything immediately, including any outstanding request.
- Memory contract:
  - Responses are in order, one per request.
  - Latency is 1 or more cycles, i.e. the earliest response is in the cycle after o_i_valid_addr=1.
  - At most one request is outstanding.
- Request issue (registered):
  - At a posedge, issue when i_redirect_valid=0, outstanding=0 and o_q_count<DEPTH.
  - On issue: o_i_valid_addr=1 for exactly one cycle, o_i_addr=fetch_pc, outstanding=1, req_addr=fetch_pc, fetch_pc+=PC_STEP modulo 2^ADDR_W (full-width wrap).
  - The first request is visible after the first posedge following reset release, with o_i_addr=RESET_PC.
- Response at a posedge with i_i_valid_inst=1:
  - If outstanding=0: the response is spurious and is ignored.
  - Else if discard=1 or i_redirect_valid=1: the response is dropped; outstanding=0, discard=0.
  - Else: {i_i_inst, req_addr} is pushed at the tail; outstanding=0.
  - A new request can issue at the next posedge at the earliest (no request and response in the same edge).
- Output and pop:
  - o_inst_valid=(o_q_count!=0); o_inst and o_inst_addr are driven from the head storage register (no combinational bypass from memory).
  - Response-to-o_inst_valid latency is 1 cycle.
  - Pop occurs when o_inst_valid & i_inst_ready at a posedge.
  - Push and pop at the same edge leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible by the issue rule; full means o_q_count=DEPTH with no request issued.
- Redirect (i_redirect_valid=1 at a posedge) has priority over push and pop at that edge:
  - The FIFO is flushed: count=0, pointers reset; any pop that edge is ignored.
  - fetch_pc=i_redirect_addr.
  - If outstanding=1 and no response arrives that edge, set discard=1.
  - No request is issued at the redirect edge; the next request goes to i_redirect_addr once outstanding=0.
  - Back-to-back redirects: the last one wins.

Test Plan:
- Sequential fetch (DEPTH=4, memory latency 1, inst=addr^0xA5A5A5A5, ready=1, 20 cycles): o_i_addr = 0,4,8,…; each o_inst_addr matches; o_inst=o_inst_addr^0xA5A5A5A5; requests spaced 3 cycles apart.
- Backpressure with ready=0: o_q_count climbs to 4 and o_i_valid_addr stays 0 afterwards; ready=1 for one cycle -> count 3, then one new request at 0x10.
- Redirect to 0x1000 while the request for 0x8 is outstanding with latency 3: count=0 the next cycle; the 0x8 response is dropped; the next o_i_addr is 0x1000; the first o_inst_addr after is 0x1000.
- Redirect to 0x2000 coinciding with a response and a pop at count=2: nothing is pushed; count=0; outstanding cleared; request 0x2000 issues at the next edge.
- Wrap with RESET_PC=0xFFFF_FFFF_FFFF_FFFC: second o_i_addr is 0x0; o_inst_addr sequence FFFF…FFFC then 0.
- Reset asserted mid-stream with count=3 and a request outstanding: all outputs 0 immediately; a late response after release is ignored; the first request after release is RESET_PC.
